// File: rtl/inst_sram_resp_if.sv
// rtl/inst_sram_resp_if.sv - fetch request/response bundle between PC side and instruction memory
interface inst_sram_resp_if;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [3:0]  inst_we;
    logic [31:0] inst_wdata;
    logic        inst_ready;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        inst_addr_err;

    modport master (
        output inst_en, inst_addr, inst_we, inst_wdata,
        input  inst_ready, inst_rvalid, inst_rdata, inst_addr_err
    );

    modport slave (
        input  inst_en, inst_addr, inst_we, inst_wdata,
        output inst_ready, inst_rvalid, inst_rdata, inst_addr_err
    );
endinterface

// File: rtl/inst_sram_resp.sv
// rtl/inst_sram_resp.sv - instruction memory responder with fixed latency, window decode and byte-enable writes
module inst_sram_resp #(
    parameter logic [31:0] ADDR_BASE  = 32'h1c000000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1
) (
    input  logic             clk,
    input  logic             rst,
    inst_sram_resp_if.slave  bus
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_n;
    logic [2:0]              cnt, cnt_n;
    logic                    ready;
    logic                    accept;
    logic                    fire;

    logic [31:0]             off;
    logic                    unused_off;
    logic                    dec_err;
    logic                    is_wr;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             acc_data;

    logic [31:0]             hold_data;
    logic                    hold_err;
    logic                    rvalid_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic [31:0]             mem [0:DEPTH-1];

    // Addresses below the base wrap to a huge offset and fall out of the window.
    assign off        = bus.inst_addr - ADDR_BASE;
    assign unused_off = ^off[1:0];
    assign dec_err    = (bus.inst_addr[1:0] != 2'b00) || (off[31:DEPTH_LOG2+2] != '0);
    assign idx        = off[DEPTH_LOG2+1:2];
    assign is_wr      = (bus.inst_we != 4'b0000);
    assign acc_data   = (dec_err || is_wr) ? 32'h0 : mem[idx];

    assign ready  = (LATENCY == 1) || (state == IDLE) || (cnt == 3'd1);
    assign accept = bus.inst_en && ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The final BUSY cycle both retires the current fetch and may take the next one.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire    = 1'b0;
        if (LATENCY == 1) begin
            state_n = IDLE;
            fire    = accept;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_n = BUSY;
                        cnt_n   = LAT_M1;
                    end
                end
                BUSY: begin
                    cnt_n = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        fire = 1'b1;
                        if (accept) begin
                            cnt_n = LAT_M1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_wr && !dec_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.inst_we[b]) begin
                    mem[idx][8*b +: 8] <= bus.inst_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is snapshotted at accept so the response reflects memory at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= 32'h0;
            hold_err  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= acc_data;
                hold_err  <= dec_err;
            end
            rvalid_q <= fire;
            if (fire) begin
                rdata_q <= (LATENCY == 1) ? acc_data : hold_data;
                err_q   <= (LATENCY == 1) ? dec_err  : hold_err;
            end else begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    assign bus.inst_ready    = ready;
    assign bus.inst_rvalid   = rvalid_q;
    assign bus.inst_rdata    = rdata_q;
    assign bus.inst_addr_err = err_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// tb/tb_inst_sram_resp.sv - three latencies driven in parallel against an edge-indexed reference model
module tb_inst_sram_resp;

    localparam logic [31:0] BASE = 32'h1c000000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;

    inst_sram_resp_if if1 ();
    inst_sram_resp_if if3 ();
    inst_sram_resp_if if4 ();

    assign if1.inst_en = en; assign if1.inst_addr = addr; assign if1.inst_we = we; assign if1.inst_wdata = wdata;
    assign if3.inst_en = en; assign if3.inst_addr = addr; assign if3.inst_we = we; assign if3.inst_wdata = wdata;
    assign if4.inst_en = en; assign if4.inst_addr = addr; assign if4.inst_we = we; assign if4.inst_wdata = wdata;

    inst_sram_resp #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if1.slave));
    inst_sram_resp #(.LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(if3.slave));
    inst_sram_resp #(.LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if4.slave));

    logic [2:0]  rdy, rv, er;
    logic [31:0] rd [3];

    assign rdy = {if4.inst_ready, if3.inst_ready, if1.inst_ready};
    assign rv  = {if4.inst_rvalid, if3.inst_rvalid, if1.inst_rvalid};
    assign er  = {if4.inst_addr_err, if3.inst_addr_err, if1.inst_addr_err};
    assign rd[0] = if1.inst_rdata;
    assign rd[1] = if3.inst_rdata;
    assign rd[2] = if4.inst_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
        logic        err;
    } pend_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          ecount = 0;
    bit          chk = 0;
    int          lat [3];
    int          next_ok [3];
    logic [31:0] mmem [3][4096];
    pend_t       pq [$];
    logic        exp_rv [3];
    logic [31:0] exp_rd [3];
    logic        exp_er [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    // Predicts every instance's outputs after edge ecount+1 from the request rules.
    task automatic model_edge();
        int          u;
        logic [31:0] off;
        logic        bad;
        int          widx;
        logic [31:0] data;
        u = ecount + 1;
        for (int i = 0; i < 3; i++) begin
            exp_rv[i] = 1'b0;
            exp_rd[i] = 32'h0;
            exp_er[i] = 1'b0;
            if (rst) begin
                next_ok[i] = 0;
            end else if (en && u >= next_ok[i]) begin
                off  = addr - BASE;
                bad  = (addr[1:0] != 2'b00) || (off >= 32'd16384);
                widx = int'(off >> 2) & 4095;
                data = 32'h0;
                if (!bad && we == 4'b0000) data = mmem[i][widx];
                if (!bad && we != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) mmem[i][widx][8*b +: 8] = wdata[8*b +: 8];
                end
                pq.push_back('{inst: i, due: u + lat[i] - 1, data: data, err: bad});
                next_ok[i] = u + ((lat[i] > 1) ? lat[i] - 1 : 1);
            end
        end
        for (int j = pq.size() - 1; j >= 0; j--) begin
            if (rst) begin
                pq.delete(j);
            end else if (pq[j].due == u) begin
                exp_rv[pq[j].inst] = 1'b1;
                exp_rd[pq[j].inst] = pq[j].data;
                exp_er[pq[j].inst] = pq[j].err;
                pq.delete(j);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        if (chk) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("L%0d_ready", lat[i]), 32'(rdy[i]), 32'(ecount + 1 >= next_ok[i]));
                check($sformatf("L%0d_rvalid", lat[i]), 32'(rv[i]), 32'(exp_rv[i]));
                check($sformatf("L%0d_rdata", lat[i]), rd[i], exp_rd[i]);
                check($sformatf("L%0d_err", lat[i]), 32'(er[i]), 32'(exp_er[i]));
            end
        end
        rst = r; en = e; addr = a; we = w; wdata = d;
        model_edge();
        ecount++;
        chk = 1;
    endtask

    task automatic hold(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, a, w, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, addr, 4'h0, 32'h0);
    endtask

    task automatic post_l1(input string tag, input logic [31:0] data, input logic err);
        @(posedge clk);
        #1;
        check({tag, "_rv"}, 32'(rv[0]), 32'd1);
        check({tag, "_rd"}, rd[0], data);
        check({tag, "_er"}, 32'(er[0]), 32'(err));
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 6) return BASE + 32'(4 * $urandom_range(0, 15));
        if (k == 7) return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        if (k == 8) return BASE - 32'(4 * $urandom_range(1, 4));
        return BASE + 32'h4000 + 32'(4 * $urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] ra;
        lat[0] = 1; lat[1] = 3; lat[2] = 4;
        rst = 1'b1; en = 1'b0; addr = BASE; we = 4'h0; wdata = 32'h0;

        cycle(1'b1, 1'b0, BASE, 4'h0, 32'h0);
        cycle(1'b1, 1'b0, BASE, 4'h0, 32'h0);

        hold(BASE, 4'hf, 32'h02800c0c, 4);
        cycle(1'b0, 1'b1, BASE, 4'h0, 32'h0);
        post_l1("wr_then_rd", 32'h02800c0c, 1'b0);
        hold(BASE, 4'h0, 32'h0, 3);
        idle(4);

        for (int w = 0; w < 16; w++) begin
            case (w)
                0: hold(BASE, 4'hf, 32'h11, 4);
                1: hold(BASE + 4, 4'hf, 32'h22, 4);
                2: hold(BASE + 8, 4'hf, 32'h33, 4);
                4: hold(BASE + 16, 4'hf, 32'haabbccdd, 4);
                default: hold(BASE + 32'(4 * w), 4'hf, $urandom, 4);
            endcase
        end
        idle(4);

        cycle(1'b0, 1'b1, BASE, 4'h0, 32'h0);
        post_l1("b2b_0", 32'h11, 1'b0);
        cycle(1'b0, 1'b1, BASE + 4, 4'h0, 32'h0);
        post_l1("b2b_1", 32'h22, 1'b0);
        check("b2b_ready", 32'(rdy[0]), 32'd1);
        cycle(1'b0, 1'b1, BASE + 8, 4'h0, 32'h0);
        post_l1("b2b_2", 32'h33, 1'b0);
        idle(5);

        hold(BASE + 16, 4'b0101, 32'h11223344, 4);
        cycle(1'b0, 1'b1, BASE + 16, 4'h0, 32'h0);
        post_l1("byte_en", 32'haa22cc44, 1'b0);
        hold(BASE + 16, 4'h0, 32'h0, 3);
        idle(5);

        hold(BASE + 4, 4'h0, 32'h0, 10);
        idle(5);

        cycle(1'b0, 1'b1, 32'h1c000002, 4'h0, 32'h0);
        post_l1("err_misal", 32'h0, 1'b1);
        hold(32'h1c000002, 4'h0, 32'h0, 3);
        cycle(1'b0, 1'b1, 32'h1bfffffc, 4'h0, 32'h0);
        post_l1("err_below", 32'h0, 1'b1);
        hold(32'h1bfffffc, 4'h0, 32'h0, 3);
        cycle(1'b0, 1'b1, 32'h1c004000, 4'h0, 32'h0);
        post_l1("err_above", 32'h0, 1'b1);
        hold(32'h1c004000, 4'hf, 32'hdeadbeef, 4);
        cycle(1'b0, 1'b1, BASE, 4'h0, 32'h0);
        post_l1("err_wr_nomod", 32'h11, 1'b0);
        hold(BASE, 4'h0, 32'h0, 3);
        idle(6);

        cycle(1'b0, 1'b1, BASE, 4'h0, 32'h0);
        cycle(1'b0, 1'b0, BASE, 4'h0, 32'h0);
        cycle(1'b1, 1'b1, BASE + 8, 4'hf, 32'h55);
        @(posedge clk);
        #1;
        check("rst_ready_l4", 32'(rdy[2]), 32'd1);
        check("rst_rvalid_l4", 32'(rv[2]), 32'd0);
        hold(BASE + 4, 4'h0, 32'h0, 4);
        @(posedge clk);
        #1;
        check("after_rst_rv_l4", 32'(rv[2]), 32'd1);
        check("after_rst_rd_l4", rd[2], 32'h22);
        idle(6);

        for (int n = 0; n < 3000; n++) begin
            ra = rand_addr();
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), ra,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
